// File: rtl/iq_snap_pkg.sv
// -----------------------------------------------------------------------------
// iq_snap_pkg
// Shared types and helpers for the IQ snapshot capture block.
//   - state_e       : capture sequencer states
//   - MODE_ONESHOT / MODE_CIRC : values of the 'mode' input
//   - eff_len()     : maps a requested capture length onto the RAM depth
// Optional feature macro used by the block: IQ_SNAP_CIRC_EN (circular capture).
// -----------------------------------------------------------------------------
package iq_snap_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

   localparam logic MODE_ONESHOT = 1'b0;
   localparam logic MODE_CIRC    = 1'b1;

   // A length of zero, or one larger than the RAM, means "fill the whole RAM".
   function automatic int unsigned eff_len(input int unsigned len,
                                           input int unsigned depth);
      return ((len == 0) || (len > depth)) ? depth : len;
   endfunction

endpackage

// File: rtl/iq_snap_ram_sdp.sv
// -----------------------------------------------------------------------------
// iq_snap_ram_sdp
// Simple dual-port RAM: one write port, one read port, same clock.
// Read-first: a read and a write to the same address in one cycle returns the
// word stored before the write. The read data is registered (1 cycle latency)
// and holds its value when rd_en is low.
// Ports:
//   clk                          clock
//   wr_en / wr_addr / wr_data    write port
//   rd_en / rd_addr              read request
//   rd_data                      registered read data
// -----------------------------------------------------------------------------
module iq_snap_ram_sdp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   // Both accesses in one process with non-blocking assignments: the read
   // samples the array before the write lands, giving read-first behaviour.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd_en) begin
         rd_data_q <= mem_q[rd_addr];
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/iq_snap_capture.sv
// -----------------------------------------------------------------------------
// iq_snap_capture
// Triggered snapshot buffer: stores a window of samples of one selected channel
// from a channel-interleaved stream into an internal RAM, read back through a
// two-stage registered read port.
//
// Parameters: DATA_W (word width), ADDR_W (RAM address width, DEPTH=2**ADDR_W),
//             NUM_CH (interleaved channels; CH_W = max(1, clog2(NUM_CH))).
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_valid, in_ch, in_data      input sample stream
//   ch_sel, cap_len, mode         capture setup, latched on arm
//   arm, trig, stop               single-cycle control pulses
//   rd_en, rd_addr                read request
//   rd_data, rd_valid             read response (2-cycle latency)
//   armed, busy, done, wrapped    status
//   wr_count                      samples stored, saturating at DEPTH
//   last_addr                     address of most recent write
//
// Optional feature macro: IQ_SNAP_CIRC_EN
//   defined   : circular mode (mode=1), stop-terminated capture, wrapped flag.
//   undefined : mode is ignored (one-shot only), wrapped is tied low.
// -----------------------------------------------------------------------------
module iq_snap_capture
   import iq_snap_pkg::*;
#(
   parameter  int DATA_W = 32,
   parameter  int ADDR_W = 10,
   parameter  int NUM_CH = 1,
   localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CH_W-1:0]   ch_sel,
   input  logic [ADDR_W:0]   cap_len,
   input  logic              mode,
   input  logic              arm,
   input  logic              trig,
   input  logic              stop,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              armed,
   output logic              busy,
   output logic              done,
   output logic              wrapped,
   output logic [ADDR_W:0]   wr_count,
   output logic [ADDR_W-1:0] last_addr
);

   localparam int               DEPTH   = 2 ** ADDR_W;
   localparam logic [ADDR_W:0]  DEPTH_W = (ADDR_W + 1)'(DEPTH);

   // ---------------------------------------------------------------------
   // Control state
   // ---------------------------------------------------------------------
   state_e              state_q,     state_d;
   logic [CH_W-1:0]     ch_sel_q,    ch_sel_d;
   logic [ADDR_W:0]     len_q,       len_d;
   logic [ADDR_W-1:0]   wr_ptr_q,    wr_ptr_d;
   logic [ADDR_W:0]     wr_count_q,  wr_count_d;
   logic [ADDR_W-1:0]   last_addr_q, last_addr_d;

   logic                ch_match;
   logic                wr_en;
   logic                circ;
   logic [ADDR_W:0]     cap_len_eff;

   assign cap_len_eff = (ADDR_W + 1)'(eff_len(32'(cap_len), DEPTH));

`ifdef IQ_SNAP_CIRC_EN
   logic                mode_q,      mode_d;
   logic                wrapped_q,   wrapped_d;

   assign circ    = (mode_q == MODE_CIRC);
   assign wrapped = wrapped_q;
`else
   logic                unused_mode;

   assign unused_mode = mode;
   assign circ        = 1'b0;
   assign wrapped     = 1'b0;
`endif

   // ---------------------------------------------------------------------
   // Next-state / write decode
   // ---------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ch_sel_d    = ch_sel_q;
      len_d       = len_q;
      wr_ptr_d    = wr_ptr_q;
      wr_count_d  = wr_count_q;
      last_addr_d = last_addr_q;
`ifdef IQ_SNAP_CIRC_EN
      mode_d      = mode_q;
      wrapped_d   = wrapped_q;
`endif
      wr_en       = 1'b0;
      ch_match    = in_valid && (in_ch == ch_sel_q);

      if (arm) begin
         // arm wins over everything else in the same cycle and never writes.
         state_d    = ST_ARMED;
         ch_sel_d   = ch_sel;
         len_d      = cap_len_eff;
         wr_ptr_d   = '0;
         wr_count_d = '0;
`ifdef IQ_SNAP_CIRC_EN
         mode_d     = mode;
         wrapped_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            ST_ARMED: begin
               if (stop) begin
                  state_d = ST_IDLE;
               end else if (trig) begin
                  // A matching sample in the trigger cycle is the first word.
                  state_d = ST_CAPTURE;
                  wr_en   = ch_match;
               end
            end
            ST_CAPTURE: begin
               wr_en = ch_match;
`ifdef IQ_SNAP_CIRC_EN
               // The sample in the stop cycle is still stored (wr_en above).
               if (circ && stop) begin
                  state_d = ST_DONE;
               end
`endif
            end
            default: begin
            end
         endcase

         if (wr_en) begin
            wr_ptr_d    = wr_ptr_q + 1'b1;   // wraps naturally at DEPTH
            last_addr_d = wr_ptr_q;
            if (wr_count_q != DEPTH_W) begin
               wr_count_d = wr_count_q + 1'b1;
            end
            if (circ) begin
`ifdef IQ_SNAP_CIRC_EN
               if (wr_ptr_q == '1) begin
                  wrapped_d = 1'b1;
               end
`endif
            end else if ((wr_count_q + 1'b1) == len_q) begin
               state_d = ST_DONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ch_sel_q    <= '0;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         wr_count_q  <= '0;
         last_addr_q <= '0;
`ifdef IQ_SNAP_CIRC_EN
         mode_q      <= MODE_ONESHOT;
         wrapped_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         ch_sel_q    <= ch_sel_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         wr_count_q  <= wr_count_d;
         last_addr_q <= last_addr_d;
`ifdef IQ_SNAP_CIRC_EN
         mode_q      <= mode_d;
         wrapped_q   <= wrapped_d;
`endif
      end
   end

   assign armed     = (state_q == ST_ARMED);
   assign busy      = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
   assign done      = (state_q == ST_DONE);
   assign wr_count  = wr_count_q;
   assign last_addr = last_addr_q;

   // ---------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------
   logic [DATA_W-1:0] ram_rd_data;

   iq_snap_ram_sdp #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (ram_rd_data)
   );

   // ---------------------------------------------------------------------
   // Read pipeline: RAM output register, then the output register below.
   // The valid pipe is reset so a reset drops reads already in flight.
   // ---------------------------------------------------------------------
   logic              rd_v1_q,    rd_v1_d;
   logic              rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0] rd_data_q,  rd_data_d;

   always_comb begin
      rd_v1_d    = rd_en;
      rd_valid_d = rd_v1_q;
      rd_data_d  = rd_data_q;
      if (rd_v1_q) begin
         rd_data_d = ram_rd_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_v1_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_v1_q    <= rd_v1_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_iq_snap_capture.sv
// -----------------------------------------------------------------------------
// tb_iq_snap_capture
// Directed bench for iq_snap_capture with NUM_CH=4, ADDR_W=3 (DEPTH=8).
// Expectations follow IQ_SNAP_CIRC_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_iq_snap_capture;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 3;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic [CH_W-1:0]   in_ch;
   logic [DATA_W-1:0] in_data;
   logic [CH_W-1:0]   ch_sel;
   logic [ADDR_W:0]   cap_len;
   logic              mode;
   logic              arm;
   logic              trig;
   logic              stop;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              armed;
   logic              busy;
   logic              done;
   logic              wrapped;
   logic [ADDR_W:0]   wr_count;
   logic [ADDR_W-1:0] last_addr;

   int checks = 0;
   int errors = 0;

   iq_snap_capture #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NUM_CH (NUM_CH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ch     (in_ch),
      .in_data   (in_data),
      .ch_sel    (ch_sel),
      .cap_len   (cap_len),
      .mode      (mode),
      .arm       (arm),
      .trig      (trig),
      .stop      (stop),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .armed     (armed),
      .busy      (busy),
      .done      (done),
      .wrapped   (wrapped),
      .wr_count  (wr_count),
      .last_addr (last_addr)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   typedef struct {
      logic              arm;
      logic              trig;
      logic              stop;
      logic              vld;
      logic [CH_W-1:0]   ch;
      logic [DATA_W-1:0] data;
      logic              e_armed;
      logic              e_busy;
      logic              e_done;
      logic [ADDR_W:0]   e_wc;
      logic [ADDR_W-1:0] e_la;
   } vec_t;

   vec_t              vecs [13];
   logic [DATA_W-1:0] mem_exp [8];

   // Inputs change 1 time unit after the edge; outputs are checked there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_status(input string tag, input logic e_armed, input logic e_busy,
                             input logic e_done, input logic e_wrapped,
                             input logic [ADDR_W:0] e_wc, input logic [ADDR_W-1:0] e_la);
      chk({tag, ".armed"},     32'(armed),     32'(e_armed));
      chk({tag, ".busy"},      32'(busy),      32'(e_busy));
      chk({tag, ".done"},      32'(done),      32'(e_done));
      chk({tag, ".wrapped"},   32'(wrapped),   32'(e_wrapped));
      chk({tag, ".wr_count"},  32'(wr_count),  32'(e_wc));
      chk({tag, ".last_addr"}, 32'(last_addr), 32'(e_la));
   endtask

   // Single read: rd_valid must be low one edge after the request, high after two.
   task automatic rd1(input string nm, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
      rd_en   = 1'b1;
      rd_addr = a;
      tick();
      rd_en = 1'b0;
      chk({nm, ".lat1"}, 32'(rd_valid), 32'd0);
      tick();
      chk({nm, ".rd_valid"}, 32'(rd_valid), 32'd1);
      chk({nm, ".rd_data"}, rd_data, exp);
      $display("read %s addr=%0d data=%0h", nm, a, rd_data);
   endtask

   task automatic do_arm(input logic [CH_W-1:0] cs, input logic [ADDR_W:0] len, input logic md);
      ch_sel  = cs;
      cap_len = len;
      mode    = md;
      arm     = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_ch    = '0;
      in_data  = '0;
      ch_sel   = '0;
      cap_len  = '0;
      mode     = 1'b0;
      arm      = 1'b0;
      trig     = 1'b0;
      stop     = 1'b0;
      rd_en    = 1'b0;
      rd_addr  = '0;

      // Sequencing table: ch_sel=2, cap_len=2, one-shot.
      //              arm  trig stop vld  ch    data    armed busy done wc la
      vecs[0]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h00, 1'b0,1'b0,1'b0,4'd0,3'd0}; // trig in IDLE ignored
      vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,32'h00, 1'b1,1'b1,1'b0,4'd0,3'd0}; // arm
      vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,2'd0,32'h00, 1'b0,1'b0,1'b0,4'd0,3'd0}; // stop disarms
      vecs[3]  = '{1'b1,1'b1,1'b0,1'b1,2'd2,32'h11, 1'b1,1'b1,1'b0,4'd0,3'd0}; // arm+trig -> ARMED only
      vecs[4]  = '{1'b0,1'b1,1'b0,1'b1,2'd2,32'h22, 1'b0,1'b1,1'b0,4'd1,3'd0}; // trig + sample -> addr 0
      vecs[5]  = '{1'b0,1'b0,1'b0,1'b1,2'd1,32'h33, 1'b0,1'b1,1'b0,4'd1,3'd0}; // other channel
      vecs[6]  = '{1'b0,1'b0,1'b1,1'b1,2'd2,32'h44, 1'b0,1'b0,1'b1,4'd2,3'd1}; // stop ignored, last write
      vecs[7]  = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h00, 1'b0,1'b0,1'b1,4'd2,3'd1}; // trig in DONE ignored
      vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,2'd2,32'h55, 1'b0,1'b0,1'b1,4'd2,3'd1}; // no write in DONE
      vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,2'd0,32'h00, 1'b1,1'b1,1'b0,4'd0,3'd1}; // re-arm, last_addr held
      vecs[10] = '{1'b0,1'b1,1'b0,1'b0,2'd0,32'h00, 1'b0,1'b1,1'b0,4'd0,3'd1}; // trig, no sample
      vecs[11] = '{1'b1,1'b0,1'b0,1'b1,2'd2,32'h66, 1'b1,1'b1,1'b0,4'd0,3'd1}; // arm beats sample
      vecs[12] = '{1'b0,1'b0,1'b1,1'b0,2'd0,32'h00, 1'b0,1'b0,1'b0,4'd0,3'd1}; // stop -> IDLE

      // ---------------- reset state ----------------
      tick();
      tick();
      chk_status("reset", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
      chk("reset.rd_valid", 32'(rd_valid), 32'd0);
      chk("reset.rd_data", rd_data, 32'd0);
      rst = 1'b0;
      tick();

      // ---------------- table-driven sequencing ----------------
      ch_sel  = 2'd2;
      cap_len = 4'd2;
      mode    = 1'b0;
      for (int i = 0; i < 13; i++) begin
         arm      = vecs[i].arm;
         trig     = vecs[i].trig;
         stop     = vecs[i].stop;
         in_valid = vecs[i].vld;
         in_ch    = vecs[i].ch;
         in_data  = vecs[i].data;
         tick();
         chk_status($sformatf("vec%0d", i), vecs[i].e_armed, vecs[i].e_busy, vecs[i].e_done,
                    1'b0, vecs[i].e_wc, vecs[i].e_la);
         $display("vec %0d armed=%0b busy=%0b done=%0b wc=%0d la=%0d",
                  i, armed, busy, done, wr_count, last_addr);
      end
      arm = 1'b0; trig = 1'b0; stop = 1'b0; in_valid = 1'b0;
      rd1("tbl_a0", 3'd0, 32'h22);
      rd1("tbl_a1", 3'd1, 32'h44);

      // ---------------- one-shot, 4 channels round robin ----------------
      do_arm(2'd2, 4'd5, 1'b0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int k = 0; k < 40; k++) begin
         in_valid = 1'b1;
         in_ch    = 2'(k % 4);
         in_data  = 32'(k);
         tick();
         if (k == 14) chk("oneshot.done_early", 32'(done), 32'd0);
         if (k == 18) chk("oneshot.done_rise", 32'(done), 32'd1);
      end
      in_valid = 1'b0;
      chk_status("oneshot", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd4);
      for (int a = 0; a < 5; a++) begin
         rd1($sformatf("oneshot_a%0d", a), 3'(a), 32'(2 + 4 * a));
      end

      // ---------------- circular (or full-depth one-shot without the macro) ----------------
      do_arm(2'd1, 4'd0, 1'b1);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int s = 1; s <= 11; s++) begin
         in_valid = 1'b1;
         in_ch    = 2'd1;
         in_data  = 32'(s);
         tick();
         if (s == 8) begin
`ifdef IQ_SNAP_CIRC_EN
            chk_status("circ_s8", 1'b0, 1'b1, 1'b0, 1'b1, 4'd8, 3'd7);
`else
            chk_status("circ_s8", 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 3'd7);
`endif
         end
      end
      in_valid = 1'b0;
      stop = 1'b1;
      tick();
      stop = 1'b0;
`ifdef IQ_SNAP_CIRC_EN
      chk_status("circ_end", 1'b0, 1'b0, 1'b1, 1'b1, 4'd8, 3'd2);
      for (int a = 0; a < 8; a++) mem_exp[a] = (a < 3) ? 32'(a + 9) : 32'(a + 1);
`else
      chk_status("circ_end", 1'b0, 1'b0, 1'b1, 1'b0, 4'd8, 3'd7);
      for (int a = 0; a < 8; a++) mem_exp[a] = 32'(a + 1);
`endif
      tick();

      // ---------------- back-to-back read-back ----------------
      for (int c = 0; c < 10; c++) begin
         rd_en   = (c < 8);
         rd_addr = 3'(c);
         tick();
         if (c >= 1 && c <= 8) begin
            chk($sformatf("pipe%0d.rd_valid", c), 32'(rd_valid), 32'd1);
            chk($sformatf("pipe%0d.rd_data", c), rd_data, mem_exp[c - 1]);
            $display("pipe read addr=%0d data=%0h", c - 1, rd_data);
         end else begin
            chk($sformatf("pipe%0d.rd_valid", c), 32'(rd_valid), 32'd0);
         end
      end
      rd_en = 1'b0;

      // ---------------- read/write collision (cap_len=1, sample in trig cycle) ----------------
      do_arm(2'd1, 4'd1, 1'b0);
      trig     = 1'b1;
      in_valid = 1'b1;
      in_ch    = 2'd1;
      in_data  = 32'hBEEF;
      rd_en    = 1'b1;
      rd_addr  = 3'd0;
      tick();
      trig = 1'b0; in_valid = 1'b0; rd_en = 1'b0;
      chk_status("coll", 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 3'd0);
      tick();
      chk("coll.rd_valid", 32'(rd_valid), 32'd1);
      chk("coll.old_word", rd_data, mem_exp[0]);
      $display("collision read addr=0 data=%0h", rd_data);
      rd1("coll_new", 3'd0, 32'hBEEF);

      // ---------------- reset mid-capture with a read in flight ----------------
      do_arm(2'd0, 4'd5, 1'b0);
      trig = 1'b1;
      tick();
      trig = 1'b0;
      for (int s = 0; s < 3; s++) begin
         in_valid = 1'b1;
         in_ch    = 2'd0;
         in_data  = 32'(8'h50 + s);
         rd_en    = (s == 2);
         rd_addr  = 3'd1;
         tick();
      end
      in_valid = 1'b0;
      rd_en    = 1'b0;
      rst      = 1'b1;
      tick();
      chk_status("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd0);
      chk("rst_mid.rd_valid", 32'(rd_valid), 32'd0);
      chk("rst_mid.rd_data", rd_data, 32'd0);
      rst = 1'b0;
      tick();
      chk("rst_after.rd_valid", 32'(rd_valid), 32'd0);

      do_arm(2'd0, 4'd5, 1'b0);
      trig = 1'b1;
      for (int s = 0; s < 5; s++) begin
         in_valid = 1'b1;
         in_ch    = 2'd0;
         in_data  = 32'(12'h100 + s);
         tick();
         trig = 1'b0;
      end
      in_valid = 1'b0;
      chk_status("rst_recap", 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 3'd4);
      rd1("recap_a0", 3'd0, 32'h100);
      rd1("recap_a4", 3'd4, 32'h104);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/iq_snap_capture.md
# iq_snap_capture

Parametrised snapshot capture buffer for the wavelength-readout datapath. It records a triggered window of IQ accumulator or average words from one selected channel of a channel-interleaved stream into an internal dual-port RAM. The RAM is read back on a registered read port that feeds the software-register/BRAM readout bridge. It adds to a plain fabric-side snapshot BRAM the arm/trigger sequencing, channel filtering, programmable length, optional circular capture and status reporting.

## Interface
- DATA_W, 32, sample and RAM word width
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W
- NUM_CH, 1, channels interleaved on the input; CH_W = max(1, clog2(NUM_CH))

- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample strobe
- in_ch  in  CH_W  channel tag of the current sample
- in_data  in  DATA_W  sample word
- ch_sel  in  CH_W  channel to capture; sampled on arm
- cap_len  in  ADDR_W+1  samples per one-shot capture; sampled on arm; 0 or >DEPTH means DEPTH
- mode  in  1  0 = one-shot, 1 = circular; sampled on arm
- arm  in  1  single-cycle pulse: (re)start sequence
- trig  in  1  single-cycle pulse: start storing
- stop  in  1  single-cycle pulse: end circular capture / disarm
- rd_en  in  1  read request
- rd_addr  in  ADDR_W  read address
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data qualifier
- armed, busy, done  out  1 each  status
- wrapped  out  1  circular write pointer wrapped at least once
- wr_count  out  ADDR_W+1  samples stored, saturating at DEPTH
- last_addr  out  ADDR_W  address of most recent write

## Operation
- Accepted sample: in_valid && in_ch == latched ch_sel, in CAPTURE or in the trigger cycle.
- States: IDLE, ARMED, CAPTURE, DONE.
- Any state + arm -> ARMED. Clears done, wrapped, wr_count and the write pointer; latches ch_sel, cap_len and mode.
- ARMED + trig -> CAPTURE. A sample accepted in the trig cycle is stored at address 0.
- ARMED + stop -> IDLE. No data is written.
- CAPTURE, one-shot: each accepted sample writes at the pointer, then the pointer increments. The write of sample number cap_len moves the block to DONE. trig and stop are ignored.
- CAPTURE, circular: the pointer wraps DEPTH-1 -> 0 and sets wrapped. stop -> DONE; a sample accepted in the stop cycle is still stored.
- DONE: holds contents and status until arm.
- arm has priority over trig and stop when they coincide. trig outside ARMED is ignored.
- armed = (ARMED). busy = (ARMED or CAPTURE). done = (DONE).
- wr_count is 0 after arm. last_addr holds its prior value until the first write.
- Reads are legal in every state. A read and a write to the same address in the same cycle return the old word (read-first).

## Timing
- Reset values: state IDLE, every status output 0, wr_count 0, last_addr 0, rd_data 0, rd_valid 0. RAM contents are not cleared.
- Write: the sample is in RAM on the edge where it is accepted. done rises the cycle after the final write.
- Read latency is 2 cycles: RAM output register, then output register. rd_valid is rd_en delayed by 2. Reads are fully pipelined, one per cycle.
- rst mid-capture aborts immediately to IDLE. It also kills read requests in flight (rd_valid forced 0).

## Configuration
- IQ_SNAP_CIRC_EN defined: circular mode, stop-terminated capture and the wrapped output are all present.
- IQ_SNAP_CIRC_EN undefined: mode is ignored and treated as 0. wrapped is tied to 0. stop only disarms from ARMED. The circular logic is not synthesised.

## Structure
- Package iq_snap_pkg:
  - the state enum;
  - the mode constants MODE_ONESHOT and MODE_CIRC;
  - a function for the effective length (maps 0 or >DEPTH to DEPTH).
- Sub-module iq_snap_ram_sdp: simple dual-port RAM with one write port, one read port, read-first behaviour and a registered output, parametrised by DATA_W and ADDR_W.
- The control FSM, counters and read pipeline live in the top module.

## Test plan
- One-shot: NUM_CH=4, ch_sel=2, cap_len=5, arm, trig, then 40 cycles of continuous round-robin input with data equal to the cycle index -> 5 words from channel 2 at addresses 0..4. done is asserted. wr_count=5, last_addr=4.
- Simultaneous: trig with an accepted sample in the same cycle -> that sample is at address 0. arm+trig in the same cycle -> ARMED only.
- Circular (macro on): ADDR_W=3, mode=1, write 11 samples with values 1..11, then stop -> wrapped=1, wr_count=8, last_addr=2. Address 2 holds 11 and address 3 holds 4.
- Macro off: the same stimulus with mode=1 -> one-shot with cap_len=8 (DEPTH), so done asserts after 8 samples and wrapped=0.
- Read-back: back-to-back rd_en over addresses 0..7 -> rd_valid/rd_data arrive 2 cycles later, in order. A read colliding with a write returns the old word.
- Reset mid-capture after 3 samples -> next cycle state is IDLE and every output is 0. A new arm+trig capture then proceeds normally.
